// File: rtl/vga_pkg.sv
// vga_pkg: shared codes for the game FSM, the scheduler state encoding and the frozen draw snapshot.
// Rev 1.0
`default_nettype none

package vga_pkg;

  localparam logic [3:0] LOC_ROOT   = 4'd0;
  localparam logic [3:0] LOC_HOME   = 4'd1;
  localparam logic [3:0] LOC_ARCADE = 4'd2;
  localparam logic [3:0] LOC_GAME   = 4'd3;
  localparam logic [3:0] LOC_END    = 4'd4;

  localparam logic [3:0] ACT_STAY   = 4'd0;
  localparam logic [3:0] ACT_EAT    = 4'd1;
  localparam logic [3:0] ACT_SLEEP  = 4'd2;

  localparam logic [3:0] GS_SPIN    = 4'd0;
  localparam logic [3:0] GS_NUN     = 4'd1;
  localparam logic [3:0] GS_GIMEL   = 4'd2;
  localparam logic [3:0] GS_HAY     = 4'd3;
  localparam logic [3:0] GS_SHIN    = 4'd4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    REQUEST = ST_REQUEST,
    RELEASE = ST_RELEASE
  } sched_state_e;

  typedef struct packed {
    logic [3:0] location;
    logic [3:0] action;
    logic [3:0] game_state;
  } snapshot_t;

endpackage

`default_nettype wire

// File: rtl/tick_counter.sv
// tick_counter: free-running modulo-MAX counter with a one-cycle pulse on its last count.
// Rev 1.0
`default_nettype none

module tick_counter #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/redraw_scheduler.sv
// redraw_scheduler: issues draw requests to the VGA engine and freezes the game snapshot per draw.
// Rev 1.0
`default_nettype none

module redraw_scheduler
  import vga_pkg::*;
#(
  parameter int FRAME_TICKS = 10_000_000,
  parameter int TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] locationIn,
  input  logic [3:0] actionIn,
  input  logic [3:0] gameStateIn,
  input  logic       forceRedraw,
  input  logic       drawDone,
  output logic       start,
  output logic [3:0] location,
  output logic [3:0] action,
  output logic [3:0] gameState,
  output logic       busy,
  output logic [7:0] frameCount,
  output logic       timeoutErr
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_e    state_q, state_d;
  snapshot_t       snap_q, snap_d;
  logic            pending_q, pending_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            timeout_err_q, timeout_err_d;

  logic            tick;
  logic            trigger;
  snapshot_t       live;

  tick_counter #(
    .MAX    (FRAME_TICKS)
  ) u_frame_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  always_comb begin
    live       = '{location: locationIn, action: actionIn, game_state: gameStateIn};
    trigger    = tick | forceRedraw | (live != snap_q);

    state_d       = state_q;
    snap_d        = snap_q;
    pending_d     = pending_q | (trigger && (state_q != IDLE));
    wd_d          = wd_q;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          snap_d    = live;
          pending_d = 1'b0;
          wd_d      = '0;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        // A completed draw wins over a watchdog expiry in the same cycle.
        if (drawDone) begin
          state_d       = RELEASE;
          frame_count_d = frame_count_q + 8'd1;
        end else if (wd_q == WD_LAST) begin
          state_d       = RELEASE;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!drawDone) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      snap_q        <= '0;
      pending_q     <= 1'b0;
      wd_q          <= '0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      pending_q     <= pending_d;
      wd_q          <= wd_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign start      = (state_q == REQUEST);
  assign busy       = (state_q != IDLE);
  assign location   = snap_q.location;
  assign action     = snap_q.action;
  assign gameState  = snap_q.game_state;
  assign frameCount = frame_count_q;
  assign timeoutErr = timeout_err_q;

endmodule

`default_nettype wire
